// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, operation codes and the flag word layout
// used by the ALU and the blocks that talk to it.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SHL = 3'b101,
        ALU_SHR = 3'b110,
        ALU_CMP = 3'b111
    } alu_op_e;

    // Bit 3 is sign, bit 0 is carry.
    typedef struct packed {
        logic sign;
        logic overflow;
        logic zero;
        logic carry;
    } alu_flags_t;

    localparam int FLAG_CARRY    = 0;
    localparam int FLAG_ZERO     = 1;
    localparam int FLAG_OVERFLOW = 2;
    localparam int FLAG_SIGN     = 3;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 32-bit ALU: registers one request, holds the ALU inputs for
// SETTLE cycles, captures result/flags and returns them on a valid/ready response port.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int TAG_W  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_op1,
    input  logic [WIDTH-1:0] req_op2,
    input  logic [2:0]       req_operation,
    input  logic             req_mode,
    input  logic [TAG_W-1:0] req_tag,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [2:0]       alu_operation,
    output logic             alu_mode,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_sign,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [3:0]       sticky_flags,
    input  logic             clr_sticky,
    output logic [15:0]      op_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

    state_e           state_reg;
    logic [3:0]       settle_cnt_reg;
    logic [WIDTH-1:0] alu_op1_reg;
    logic [WIDTH-1:0] alu_op2_reg;
    logic [2:0]       alu_operation_reg;
    logic             alu_mode_reg;
    logic [TAG_W-1:0] req_tag_reg;
    logic [WIDTH-1:0] rsp_data_reg;
    alu_flags_t       rsp_flags_reg;
    logic [TAG_W-1:0] rsp_tag_reg;
    logic [3:0]       sticky_reg;
    logic [15:0]      op_count_reg;

    alu_flags_t       flags_in;
    logic             accept;
    logic             capture;

    assign flags_in = '{sign: alu_sign, overflow: alu_overflow, zero: alu_zero, carry: alu_carry};

    // RESP overlaps with the next accept when the consumer takes the response this cycle.
    assign req_ready = (state_reg == ST_IDLE) || ((state_reg == ST_RESP) && rsp_ready);
    assign accept    = req_valid && req_ready;
    assign capture   = (state_reg == ST_WAIT) && (settle_cnt_reg == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            settle_cnt_reg    <= '0;
            alu_op1_reg       <= '0;
            alu_op2_reg       <= '0;
            alu_operation_reg <= '0;
            alu_mode_reg      <= 1'b0;
            req_tag_reg       <= '0;
            rsp_data_reg      <= '0;
            rsp_flags_reg     <= '0;
            rsp_tag_reg       <= '0;
            sticky_reg        <= '0;
            op_count_reg      <= '0;
        end else begin
            if (accept) begin
                alu_op1_reg       <= req_op1;
                alu_op2_reg       <= req_op2;
                alu_operation_reg <= req_operation;
                alu_mode_reg      <= req_mode;
                req_tag_reg       <= req_tag;
                settle_cnt_reg    <= SETTLE_INIT;
            end else if (state_reg == ST_WAIT && settle_cnt_reg != 4'd0) begin
                settle_cnt_reg <= settle_cnt_reg - 4'd1;
            end

            if (capture) begin
                rsp_data_reg  <= alu_out;
                rsp_flags_reg <= flags_in;
                rsp_tag_reg   <= req_tag_reg;
            end

            // A capture in the same cycle as a clear wins over the clear.
            if (capture) begin
                sticky_reg <= clr_sticky ? 4'(flags_in) : (sticky_reg | 4'(flags_in));
            end else if (clr_sticky) begin
                sticky_reg <= '0;
            end

            if (state_reg == ST_RESP && rsp_ready) begin
                op_count_reg <= op_count_reg + 16'd1;
            end

            case (state_reg)
                ST_IDLE: if (accept) state_reg <= ST_WAIT;
                ST_WAIT: if (capture) state_reg <= ST_RESP;
                ST_RESP: if (rsp_ready) state_reg <= accept ? ST_WAIT : ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign alu_op1       = alu_op1_reg;
    assign alu_op2       = alu_op2_reg;
    assign alu_operation = alu_operation_reg;
    assign alu_mode      = alu_mode_reg;
    assign rsp_valid     = (state_reg == ST_RESP);
    assign rsp_data      = rsp_data_reg;
    assign rsp_flags     = rsp_flags_reg;
    assign rsp_tag       = rsp_tag_reg;
    assign sticky_flags  = sticky_reg;
    assign op_count      = op_count_reg;
    assign busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench: two controllers (SETTLE=1 and SETTLE=3), each driving an adder stub
// that stands in for the ALU; expected values are hand-computed constants.
module tb_alu_issue_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // ---------------- instance a: SETTLE = 1 ----------------
    logic        a_req_valid = 1'b0, a_req_ready, a_req_mode = 1'b0;
    logic [31:0] a_req_op1 = '0, a_req_op2 = '0;
    logic [2:0]  a_req_operation = '0, a_alu_operation;
    logic [3:0]  a_req_tag = '0, a_rsp_tag, a_rsp_flags, a_sticky;
    logic [31:0] a_alu_op1, a_alu_op2, a_alu_out, a_rsp_data;
    logic        a_alu_mode, a_c, a_z, a_v, a_s;
    logic        a_rsp_valid, a_rsp_ready = 1'b1, a_clr_sticky = 1'b0, a_busy;
    logic [15:0] a_op_count;

    // ---------------- instance b: SETTLE = 3 ----------------
    logic        b_req_valid = 1'b0, b_req_ready, b_req_mode = 1'b0;
    logic [31:0] b_req_op1 = '0, b_req_op2 = '0;
    logic [2:0]  b_req_operation = '0, b_alu_operation;
    logic [3:0]  b_req_tag = '0, b_rsp_tag, b_rsp_flags, b_sticky;
    logic [31:0] b_alu_op1, b_alu_op2, b_alu_out, b_rsp_data;
    logic        b_alu_mode, b_c, b_z, b_v, b_s;
    logic        b_rsp_valid, b_rsp_ready = 1'b0, b_clr_sticky = 1'b0, b_busy;
    logic [15:0] b_op_count;

    // Adder stubs with standard flags.
    logic [32:0] a_sum, b_sum;
    assign a_sum     = {1'b0, a_alu_op1} + {1'b0, a_alu_op2};
    assign a_alu_out = a_sum[31:0];
    assign a_c       = a_sum[32];
    assign a_z       = (a_sum[31:0] == 32'd0);
    assign a_s       = a_sum[31];
    assign a_v       = (a_alu_op1[31] == a_alu_op2[31]) && (a_sum[31] != a_alu_op1[31]);

    assign b_sum     = {1'b0, b_alu_op1} + {1'b0, b_alu_op2};
    assign b_alu_out = b_sum[31:0];
    assign b_c       = b_sum[32];
    assign b_z       = (b_sum[31:0] == 32'd0);
    assign b_s       = b_sum[31];
    assign b_v       = (b_alu_op1[31] == b_alu_op2[31]) && (b_sum[31] != b_alu_op1[31]);

    alu_issue_ctrl #(.WIDTH(32), .TAG_W(4), .SETTLE(1)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_op1(a_req_op1), .req_op2(a_req_op2),
        .req_operation(a_req_operation), .req_mode(a_req_mode), .req_tag(a_req_tag),
        .alu_op1(a_alu_op1), .alu_op2(a_alu_op2),
        .alu_operation(a_alu_operation), .alu_mode(a_alu_mode),
        .alu_out(a_alu_out), .alu_carry(a_c), .alu_zero(a_z),
        .alu_overflow(a_v), .alu_sign(a_s),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_data(a_rsp_data), .rsp_flags(a_rsp_flags), .rsp_tag(a_rsp_tag),
        .sticky_flags(a_sticky), .clr_sticky(a_clr_sticky),
        .op_count(a_op_count), .busy(a_busy)
    );

    alu_issue_ctrl #(.WIDTH(32), .TAG_W(4), .SETTLE(3)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_op1(b_req_op1), .req_op2(b_req_op2),
        .req_operation(b_req_operation), .req_mode(b_req_mode), .req_tag(b_req_tag),
        .alu_op1(b_alu_op1), .alu_op2(b_alu_op2),
        .alu_operation(b_alu_operation), .alu_mode(b_alu_mode),
        .alu_out(b_alu_out), .alu_carry(b_c), .alu_zero(b_z),
        .alu_overflow(b_v), .alu_sign(b_s),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_data(b_rsp_data), .rsp_flags(b_rsp_flags), .rsp_tag(b_rsp_tag),
        .sticky_flags(b_sticky), .clr_sticky(b_clr_sticky),
        .op_count(b_op_count), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("a_rst_req_ready", 32'(a_req_ready), 32'd1);
        check("a_rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        check("a_rst_busy", 32'(a_busy), 32'd0);
        check("a_rst_op_count", 32'(a_op_count), 32'd0);
        check("a_rst_alu_op1", a_alu_op1, 32'd0);
        check("a_rst_rsp_data", a_rsp_data, 32'd0);
        check("a_rst_sticky", 32'(a_sticky), 32'd0);
        check("b_rst_req_ready", 32'(b_req_ready), 32'd1);
        $display("txn reset: checks done");

        // 1 + 1, tag 3
        a_req_valid = 1'b1; a_req_op1 = 32'd1; a_req_op2 = 32'd1; a_req_tag = 4'd3;
        @(negedge clk);
        a_req_valid = 1'b0;
        check("t1_wait_busy", 32'(a_busy), 32'd1);
        check("t1_wait_rsp_valid", 32'(a_rsp_valid), 32'd0);
        check("t1_alu_op1", a_alu_op1, 32'd1);
        @(negedge clk);
        check("t1_rsp_valid", 32'(a_rsp_valid), 32'd1);
        check("t1_rsp_data", a_rsp_data, 32'd2);
        check("t1_rsp_flags", 32'(a_rsp_flags), 32'h0);
        check("t1_rsp_tag", 32'(a_rsp_tag), 32'd3);
        @(negedge clk);
        check("t1_done_rsp_valid", 32'(a_rsp_valid), 32'd0);
        check("t1_op_count", 32'(a_op_count), 32'd1);
        $display("txn 1+1 tag3: data=%0h flags=%0h count=%0d", a_rsp_data, a_rsp_flags, a_op_count);

        // 0xFFFFFFFF + 1 -> zero and carry
        a_req_valid = 1'b1; a_req_op1 = 32'hFFFF_FFFF; a_req_op2 = 32'd1; a_req_tag = 4'd5;
        @(negedge clk);
        a_req_valid = 1'b0;
        @(negedge clk);
        check("t2_rsp_data", a_rsp_data, 32'd0);
        check("t2_rsp_flags", 32'(a_rsp_flags), 32'h3);
        check("t2_rsp_tag", 32'(a_rsp_tag), 32'd5);
        check("t2_sticky", 32'(a_sticky), 32'h3);
        @(negedge clk);
        check("t2_op_count", 32'(a_op_count), 32'd2);
        a_clr_sticky = 1'b1;
        @(negedge clk);
        a_clr_sticky = 1'b0;
        check("t2_sticky_clr", 32'(a_sticky), 32'h0);
        $display("txn ffffffff+1: flags=3 sticky cleared");

        // Back-to-back stream of four requests, one response every two cycles
        for (int i = 1; i <= 4; i++) begin
            a_req_valid = 1'b1;
            a_req_op1 = 32'(i); a_req_op2 = 32'(i); a_req_tag = 4'(i);
            @(negedge clk);
            @(negedge clk);
            check("b2b_rsp_valid", 32'(a_rsp_valid), 32'd1);
            check("b2b_rsp_tag", 32'(a_rsp_tag), 32'(i));
            check("b2b_rsp_data", a_rsp_data, 32'(2 * i));
            check("b2b_req_ready", 32'(a_req_ready), 32'd1);
            $display("txn stream %0d: tag=%0d data=%0h", i, a_rsp_tag, a_rsp_data);
        end
        a_req_valid = 1'b0;
        @(negedge clk);
        check("b2b_idle", 32'(a_rsp_valid), 32'd0);
        check("b2b_op_count", 32'(a_op_count), 32'd6);

        // SETTLE=3 with back-pressure
        b_req_valid = 1'b1; b_req_op1 = 32'd7; b_req_op2 = 32'd8; b_req_tag = 4'd9;
        @(negedge clk);
        b_req_op1 = 32'd100; b_req_tag = 4'd10;
        check("s3_c1_rsp_valid", 32'(b_rsp_valid), 32'd0);
        check("s3_c1_req_ready", 32'(b_req_ready), 32'd0);
        @(negedge clk);
        check("s3_c2_rsp_valid", 32'(b_rsp_valid), 32'd0);
        @(negedge clk);
        check("s3_c3_rsp_valid", 32'(b_rsp_valid), 32'd0);
        @(negedge clk);
        check("s3_rise_rsp_valid", 32'(b_rsp_valid), 32'd1);
        check("s3_rise_data", b_rsp_data, 32'd15);
        check("s3_rise_tag", 32'(b_rsp_tag), 32'd9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("s3_hold_rsp_valid", 32'(b_rsp_valid), 32'd1);
            check("s3_hold_data", b_rsp_data, 32'd15);
            check("s3_hold_tag", 32'(b_rsp_tag), 32'd9);
            check("s3_hold_req_ready", 32'(b_req_ready), 32'd0);
            check("s3_hold_alu_op1", b_alu_op1, 32'd7);
        end
        b_req_valid = 1'b0; b_rsp_ready = 1'b1;
        #1;
        check("s3_release_req_ready", 32'(b_req_ready), 32'd1);
        @(negedge clk);
        b_rsp_ready = 1'b0;
        check("s3_done_rsp_valid", 32'(b_rsp_valid), 32'd0);
        check("s3_done_op_count", 32'(b_op_count), 32'd1);
        check("s3_done_busy", 32'(b_busy), 32'd0);
        @(negedge clk);
        check("s3_single_handshake", 32'(b_op_count), 32'd1);
        $display("txn settle3 7+8 tag9: data=%0h count=%0d", b_rsp_data, b_op_count);

        // Reset while a request is in WAIT
        b_req_valid = 1'b1; b_req_op1 = 32'd1; b_req_op2 = 32'd2; b_req_tag = 4'd4;
        @(negedge clk);
        b_req_valid = 1'b0;
        check("rstw_busy_before", 32'(b_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstw_rsp_valid", 32'(b_rsp_valid), 32'd0);
        check("rstw_busy", 32'(b_busy), 32'd0);
        check("rstw_op_count", 32'(b_op_count), 32'd0);
        check("rstw_alu_op1", b_alu_op1, 32'd0);
        check("rstw_rsp_tag", 32'(b_rsp_tag), 32'd0);
        check("rstw_a_op_count", 32'(a_op_count), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rstw_no_late_rsp", 32'(b_rsp_valid), 32'd0);
            check("rstw_count_held", 32'(b_op_count), 32'd0);
        end
        $display("txn reset-in-wait: no response emitted");

        // op_count wrap from 0xFFFF
        force dut_a.op_count_reg = 16'hFFFF;
        #1;
        release dut_a.op_count_reg;
        #1;
        check("wrap_preload", 32'(a_op_count), 32'h0000_FFFF);
        a_req_valid = 1'b1; a_req_op1 = 32'd2; a_req_op2 = 32'd3; a_req_tag = 4'd6;
        @(negedge clk);
        a_req_valid = 1'b0;
        @(negedge clk);
        check("wrap_rsp_data", a_rsp_data, 32'd5);
        check("wrap_before_hs", 32'(a_op_count), 32'h0000_FFFF);
        @(negedge clk);
        check("wrap_op_count", 32'(a_op_count), 32'd0);
        $display("txn wrap: op_count=%0h", a_op_count);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no end of test, expected finish");
        $fatal(1, "timeout");
    end

endmodule
